// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access (data first), runs the req/ready handshake and drives pipeline stalls.
// Build option: define MEM_TIMEOUT_EN to add an access watchdog that aborts hung accesses and raises a sticky bus_error.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  // instruction fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  // data side
  input  logic              dm_re,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // pipeline control
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_error
);

  typedef enum logic [1:0] {
    IDLE,
    DATA_ACC,
    FETCH_ACC,
    DONE
  } state_t;

  state_t            state;
  logic              dm_any;
  logic              timeout_hit;
  logic [DATA_W-1:0] rd_value;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  assign dm_any = dm_re | dm_we;

  // Stalls depend on the live request lines so the pipeline freezes in the very cycle a request appears.
  assign stall_mem = dm_any & ~dm_valid;
  assign stall_if  = stall_mem | (if_req & ~if_valid);

  // An aborted access returns zero; a real completion returns the memory data.
  assign rd_value = mem_ready ? mem_rdata : '0;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic             in_acc;
  logic [CNT_W-1:0] acc_cnt;

  assign in_acc      = (state == DATA_ACC) || (state == FETCH_ACC);
  assign timeout_hit = in_acc && !mem_ready && (acc_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter is held at zero outside the access states, so it starts from zero on every entry.
  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_cnt   <= '0;
      bus_error <= 1'b0;
    end else if (in_acc) begin
      if (!mem_ready) begin
        acc_cnt <= acc_cnt + CNT_W'(1);
      end
      if (timeout_hit) begin
        bus_error <= 1'b1;
      end
    end else begin
      acc_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_error   = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_rdata  <= '0;
      dm_valid  <= 1'b0;
    end else begin
      // Completion strobes are single-cycle pulses unless re-asserted below.
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_any) begin
            state     <= DATA_ACC;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else if (if_req) begin
            state    <= FETCH_ACC;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end
        end
        DATA_ACC, FETCH_ACC: begin
          if (mem_ready || timeout_hit) begin
            state   <= DONE;
            mem_req <= 1'b0;
            if (state == DATA_ACC) begin
              dm_valid <= 1'b1;
              if (!mem_we) begin
                dm_rdata <= rd_value;
              end
            end else begin
              if_valid <= 1'b1;
              if_rdata <= rd_value;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-numbered transaction model is compared on every negedge,
// plus literal checks of latency, data and priority. Timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          dm_re = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          stall_if;
  logic          stall_mem;
  logic          bus_error;

  mem_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_valid(if_valid),
    .dm_re(dm_re),
    .dm_we(dm_we),
    .dm_addr(dm_addr),
    .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata),
    .dm_valid(dm_valid),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .stall_if(stall_if),
    .stall_mem(stall_mem),
    .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [DW-1:0] mem_array [logic [AW-1:0]];
  int wait_cycles = 0;
  int wcnt        = 0;
  bit hold_ready  = 1'b0;
  bit stray       = 1'b0;

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (mem_array.exists(a)) return mem_array[a];
    return 32'hA5A5_0000 ^ a;
  endfunction

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (stray) begin
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        stray     = 1'b0;
      end else if (mem_req && !hold_ready) begin
        if (wcnt >= wait_cycles) begin
          mem_ready = 1'b1;
          if (mem_we) mem_array[mem_addr] = mem_wdata;
          else        mem_rdata = mem_read(mem_addr);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else if (!mem_req) begin
        wcnt = 0;
      end
    end
  end

  // ---------------- transaction model + per-cycle compare ----------------
  // A transaction granted in cycle s drives the bus from s+1 until the cycle r in which ready is seen
  // (or the watchdog limit), pulses its valid in r+1, and the next grant may happen in r+2 at earliest.
  bit            seen_reset = 1'b0;
  bit            tx_open    = 1'b0;
  bit            tx_data    = 1'b0;
  int            tx_start   = 0;
  int            done_cyc   = -1;
  bit            done_data  = 1'b0;
  int            free_at    = 0;
  logic [AW-1:0] m_addr     = '0;
  logic [DW-1:0] m_wdata    = '0;
  bit            m_we       = 1'b0;
  logic [DW-1:0] m_if_rdata = '0;
  logic [DW-1:0] m_dm_rdata = '0;
  bit            m_bus_err  = 1'b0;
  int            req_rises  = 0;
  logic          prev_req   = 1'b0;

  always @(negedge clock) begin : model
    bit            e_req, e_ifv, e_dmv, e_smem, e_sif, done_now;
    logic [DW-1:0] rd;
    if (seen_reset) begin
      e_req  = tx_open && (cyc > tx_start);
      e_ifv  = (cyc == done_cyc) && !done_data;
      e_dmv  = (cyc == done_cyc) && done_data;
      e_smem = (dm_re || dm_we) && !e_dmv;
      e_sif  = e_smem || (if_req && !e_ifv);
      check("mem_req", mem_req, e_req);
      if (e_req) begin
        check("mem_addr", mem_addr, m_addr);
        check("mem_we", mem_we, m_we);
        if (m_we) check("mem_wdata", mem_wdata, m_wdata);
      end
      check("if_valid", if_valid, e_ifv);
      check("dm_valid", dm_valid, e_dmv);
      check("if_rdata", if_rdata, m_if_rdata);
      check("dm_rdata", dm_rdata, m_dm_rdata);
      check("bus_error", bus_error, m_bus_err);
      check("stall_mem", stall_mem, e_smem);
      check("stall_if", stall_if, e_sif);
      if (mem_req === 1'b1 && prev_req !== 1'b1) req_rises++;
      prev_req = mem_req;
    end
    // advance the model with the inputs the DUT samples at the coming edge
    if (reset !== 1'b1) begin
      seen_reset = 1'b1;
      tx_open    = 1'b0;
      done_cyc   = -1;
      free_at    = cyc + 1;
      m_addr     = '0;
      m_wdata    = '0;
      m_we       = 1'b0;
      m_if_rdata = '0;
      m_dm_rdata = '0;
      m_bus_err  = 1'b0;
    end else if (tx_open && cyc > tx_start) begin
      done_now = 1'b0;
      rd       = '0;
      if (mem_ready === 1'b1) begin
        done_now = 1'b1;
        rd       = mem_rdata;
      end
`ifdef MEM_TIMEOUT_EN
      else if (cyc - tx_start == TO) begin
        done_now  = 1'b1;
        m_bus_err = 1'b1;
      end
`endif
      if (done_now) begin
        tx_open   = 1'b0;
        done_cyc  = cyc + 1;
        done_data = tx_data;
        free_at   = cyc + 2;
        if (!m_we) begin
          if (tx_data) m_dm_rdata = rd;
          else         m_if_rdata = rd;
        end
      end
    end else if (seen_reset && !tx_open && cyc >= free_at) begin
      if (dm_re || dm_we) begin
        tx_open  = 1'b1;
        tx_data  = 1'b1;
        tx_start = cyc;
        m_addr   = dm_addr;
        m_we     = dm_we;
        m_wdata  = dm_wdata;
      end else if (if_req) begin
        tx_open  = 1'b1;
        tx_data  = 1'b0;
        tx_start = cyc;
        m_addr   = if_addr;
        m_we     = 1'b0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_pulse(input bit data, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock);
      #1;
      if ((data ? dm_valid : if_valid) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    check(data ? "dm_valid_arrives" : "if_valid_arrives", at >= 0, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t0, a1, a2;
    mem_array[32'h40]   = 32'h0051_0093;
    mem_array[32'h44]   = 32'h0000_0113;
    mem_array[32'h48]   = 32'h0020_8233;
    mem_array[32'h1000] = 32'h1234_5678;
    mem_array[32'h100]  = 32'hCAFE_0100;
    mem_array[32'h104]  = 32'hCAFE_0104;

    tick(3);
    reset = 1'b1;
    tick(2);
    check("rst_mem_req", mem_req, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_dm_valid", dm_valid, 0);
    check("rst_bus_error", bus_error, 0);

    // fetch, zero wait
    wait_cycles = 0;
    if_addr = 32'h40;
    if_req  = 1'b1;
    t0 = cyc;
    wait_pulse(1'b0, 20, a1);
    if_req = 1'b0;
    check("fetch_latency", a1 - t0, 2);
    check("fetch_rdata", if_rdata, 32'h0051_0093);
    check("fetch_mem_addr", mem_addr, 32'h40);
    check("fetch_mem_we", mem_we, 0);
    tick();

    // simultaneous fetch and load, 3 wait cycles
    wait_cycles = 3;
    if_addr = 32'h44;
    if_req  = 1'b1;
    dm_addr = 32'h1000;
    dm_re   = 1'b1;
    t0 = cyc;
    wait_pulse(1'b1, 30, a1);
    dm_re = 1'b0;
    check("cont_data_addr", mem_addr, 32'h1000);
    check("cont_data_rdata", dm_rdata, 32'h1234_5678);
    check("cont_data_latency", a1 - t0, 5);
    check("cont_if_still_stalled", stall_if, 1);
    wait_pulse(1'b0, 30, a2);
    if_req = 1'b0;
    check("cont_fetch_latency", a2 - t0, 11);
    check("cont_fetch_rdata", if_rdata, 32'h0000_0113);
    check("cont_fetch_addr", mem_addr, 32'h44);
    tick();

    // store
    wait_cycles = 2;
    dm_addr  = 32'h2004;
    dm_wdata = 32'hDEAD_BEEF;
    dm_we    = 1'b1;
    wait_pulse(1'b1, 20, a1);
    dm_we = 1'b0;
    check("store_rdata_held", dm_rdata, 32'h1234_5678);
    check("store_mem_we", mem_we, 1);
    check("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("store_written", mem_read(32'h2004), 32'hDEAD_BEEF);
    tick(2);
    check("store_single_pulse", dm_valid, 0);

    // back-to-back loads
    req_rises   = 0;
    wait_cycles = 0;
    dm_addr = 32'h100;
    dm_re   = 1'b1;
    wait_pulse(1'b1, 20, a1);
    check("b2b_first_rdata", dm_rdata, 32'hCAFE_0100);
    dm_addr = 32'h104;
    wait_pulse(1'b1, 20, a2);
    dm_re = 1'b0;
    check("b2b_second_rdata", dm_rdata, 32'hCAFE_0104);
    check("b2b_spacing", a2 - a1, 3);
    tick(2);
    check("b2b_grant_count", req_rises, 2);

    // fetch withdrawn mid-access still completes
    wait_cycles = 3;
    if_addr = 32'h48;
    if_req  = 1'b1;
    tick(2);
    if_req = 1'b0;
    wait_pulse(1'b0, 20, a1);
    check("drop_rdata", if_rdata, 32'h0020_8233);
    check("drop_no_stall", stall_if, 0);
    tick();

    // stray ready while idle is ignored
    stray = 1'b1;
    tick(4);
    check("stray_mem_req", mem_req, 0);
    check("stray_if_rdata", if_rdata, 32'h0020_8233);

    // reset in the middle of a fetch
    wait_cycles = 20;
    if_addr = 32'h40;
    if_req  = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    reset  = 1'b1;
    if_req = 1'b0;
    check("rst2_mem_req", mem_req, 0);
    check("rst2_if_valid", if_valid, 0);
    check("rst2_dm_valid", dm_valid, 0);
    check("rst2_bus_error", bus_error, 0);
    check("rst2_if_rdata", if_rdata, 0);
    tick(2);
    wait_cycles = 0;
    if_addr = 32'h44;
    if_req  = 1'b1;
    t0 = cyc;
    wait_pulse(1'b0, 20, a1);
    if_req = 1'b0;
    check("post_rst_latency", a1 - t0, 2);
    check("post_rst_rdata", if_rdata, 32'h0000_0113);
    tick();

`ifdef MEM_TIMEOUT_EN
    // ready on the last permitted cycle wins over the timeout
    wait_cycles = 3;
    dm_addr = 32'h100;
    dm_re   = 1'b1;
    t0 = cyc;
    wait_pulse(1'b1, 20, a1);
    dm_re = 1'b0;
    check("to_edge_latency", a1 - t0, 5);
    check("to_edge_rdata", dm_rdata, 32'hCAFE_0100);
    check("to_edge_no_error", bus_error, 0);
    tick();

    // memory never answers
    hold_ready = 1'b1;
    dm_addr = 32'h300;
    dm_re   = 1'b1;
    t0 = cyc;
    wait_pulse(1'b1, 30, a1);
    dm_re = 1'b0;
    check("to_latency", a1 - t0, 5);
    check("to_rdata_zero", dm_rdata, 0);
    check("to_bus_error", bus_error, 1);
    hold_ready  = 1'b0;
    wait_cycles = 1;
    tick(3);
    check("to_sticky", bus_error, 1);
    if_addr = 32'h40;
    if_req  = 1'b1;
    wait_pulse(1'b0, 20, a1);
    if_req = 1'b0;
    check("to_next_rdata", if_rdata, 32'h0051_0093);
    check("to_next_sticky", bus_error, 1);
    tick();
`endif

    tick(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
